// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: the per-cycle operation
// encoding and the priority decode that picks exactly one operation per edge.
package pc_pkg;

  localparam logic [2:0] PC_OP_HOLD = 3'd0;
  localparam logic [2:0] PC_OP_INC  = 3'd1;
  localparam logic [2:0] PC_OP_BR   = 3'd2;
  localparam logic [2:0] PC_OP_LOAD = 3'd3;
  localparam logic [2:0] PC_OP_CALL = 3'd4;
  localparam logic [2:0] PC_OP_RET  = 3'd5;

  // Stall > Ret > Call > Load > BranchEn > IncrPc > hold. Reset is handled
  // by the registers themselves and never reaches this decode.
  function automatic logic [2:0] pc_decode(input logic stall,
                                           input logic ret,
                                           input logic call,
                                           input logic load,
                                           input logic br,
                                           input logic inc);
    if (stall)     return PC_OP_HOLD;
    else if (ret)  return PC_OP_RET;
    else if (call) return PC_OP_CALL;
    else if (load) return PC_OP_LOAD;
    else if (br)   return PC_OP_BR;
    else if (inc)  return PC_OP_INC;
    else           return PC_OP_HOLD;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and keeps the count saturated at STACK_DEPTH; a pop while empty is
// ignored. Dout always presents the current top entry.
module ret_stack #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             Empty,
  output logic             Full
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [PW-1:0]    r_top;    // next free slot; wraps modulo STACK_DEPTH
  logic [CW-1:0]    r_count;  // valid entries, 0..STACK_DEPTH
  logic [PW-1:0]    w_top_m1;

  assign w_top_m1 = r_top - 1'b1;
  assign Dout     = r_mem[w_top_m1];
  assign Empty    = (r_count == '0);
  assign Full     = (r_count == CW'(STACK_DEPTH));

  // Pointer and count: move on push/pop, cleared by reset.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Resetn) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (Push) begin
      r_top <= r_top + 1'b1;
      if (!Full) r_count <= r_count + 1'b1;
    end else if (Pop && !Empty) begin
      r_top   <= w_top_m1;
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage: written on push only.
  // NOTE: the array is deliberately not reset; contents are meaningless while
  // the count says empty, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge Clock) begin
    if (Push) r_mem[r_top] <= Din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with increment, relative branch, absolute load and a
// hardware return-address stack for call/return. One action per edge,
// chosen by priority; every result is registered onto Q.
// Build option: define PC_SAT_EN to make increment, branch and the pushed
// return address saturate instead of wrapping modulo 2^WIDTH.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Stall,
  input  logic             IncrPc,
  input  logic             Load,
  input  logic [WIDTH-1:0] R,
  input  logic             BranchEn,
  input  logic [WIDTH-1:0] Offset,
  input  logic             Call,
  input  logic             Ret,
  output logic [WIDTH-1:0] Q,
  output logic             StackEmpty,
  output logic             StackFull,
  output logic             Overflow,
  output logic             Underflow
);

  logic [WIDTH-1:0] r_q;
  logic             r_overflow;
  logic             r_underflow;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_q_inc;
  logic [WIDTH-1:0] w_q_br;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_stack_top;
  logic             w_empty;
  logic             w_full;

  assign w_op = pc_decode(Stall, Ret, Call, Load, BranchEn, IncrPc);

`ifdef PC_SAT_EN
  logic             w_br_carry;
  logic [WIDTH-1:0] w_br_sum;
  assign {w_br_carry, w_br_sum} = {1'b0, r_q} + {1'b0, Offset};
  assign w_q_inc = (&r_q) ? r_q : r_q + 1'b1;

  // Clamp the branch: a negative displacement without carry went below 0,
  // a positive one with carry went past all-ones.
  always_comb begin
    w_q_br = w_br_sum;
    if (Offset[WIDTH-1] && !w_br_carry)      w_q_br = '0;
    else if (!Offset[WIDTH-1] && w_br_carry) w_q_br = '1;
  end
`else
  assign w_q_inc = r_q + 1'b1;
  assign w_q_br  = r_q + Offset;
`endif

  ret_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Push   (w_op == PC_OP_CALL),
    .Pop    (w_op == PC_OP_RET),
    .Din    (w_q_inc),
    .Dout   (w_stack_top),
    .Empty  (w_empty),
    .Full   (w_full)
  );

  // Next PC for the selected operation; an empty Ret leaves Q in place.
  always_comb begin
    // NOTE: default assigned first so every path drives w_q_next and no
    // latch is inferred.
    w_q_next = r_q;
    case (w_op)
      PC_OP_INC:  w_q_next = w_q_inc;
      PC_OP_BR:   w_q_next = w_q_br;
      PC_OP_LOAD: w_q_next = R;
      PC_OP_CALL: w_q_next = R;
      PC_OP_RET:  if (!w_empty) w_q_next = w_stack_top;
      default:    w_q_next = r_q;
    endcase
  end

  // PC register and sticky stack-error flags; only reset clears the flags.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_q         <= RESET_VEC;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_q <= w_q_next;
      if (w_op == PC_OP_CALL && w_full)  r_overflow  <= 1'b1;
      if (w_op == PC_OP_RET  && w_empty) r_underflow <= 1'b1;
    end
  end

  assign Q          = r_q;
  assign StackEmpty = w_empty;
  assign StackFull  = w_full;
  assign Overflow   = r_overflow;
  assign Underflow  = r_underflow;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// strobes, all compared against a queue-based reference model.
module tb_pc_unit;

  localparam int          W     = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RVEC  = 16'h0010;

  logic          clock;
  logic          resetn;
  logic          stall, incr_pc, load, branch_en, call, ret;
  logic [W-1:0]  r_in, offset;
  logic [W-1:0]  q;
  logic          stack_empty, stack_full, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0]  m_q;
  logic [W-1:0]  m_stack[$];
  logic          m_ovf, m_unf;

  pc_unit #(
    .WIDTH       (W),
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (RVEC)
  ) dut (
    .Clock      (clock),
    .Resetn     (resetn),
    .Stall      (stall),
    .IncrPc     (incr_pc),
    .Load       (load),
    .R          (r_in),
    .BranchEn   (branch_en),
    .Offset     (offset),
    .Call       (call),
    .Ret        (ret),
    .Q          (q),
    .StackEmpty (stack_empty),
    .StackFull  (stack_full),
    .Overflow   (overflow),
    .Underflow  (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] model_inc(input logic [W-1:0] v);
    int s;
    s = int'(v) + 1;
`ifdef PC_SAT_EN
    if (s > 65535) s = 65535;
`endif
    return W'(s & 32'hFFFF);
  endfunction

  function automatic logic [W-1:0] model_br(input logic [W-1:0] v, input logic [W-1:0] off);
    int s;
    s = int'(v) + int'($signed(off));
`ifdef PC_SAT_EN
    if (s > 65535) s = 65535;
    if (s < 0)     s = 0;
`endif
    return W'(s & 32'hFFFF);
  endfunction

  task automatic model_step();
    if (!resetn) begin
      m_q = RVEC; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (ret) begin
      if (m_stack.size() > 0) m_q = m_stack.pop_back();
      else m_unf = 1'b1;
    end else if (call) begin
      if (m_stack.size() == DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1'b1;
      end
      m_stack.push_back(model_inc(m_q));
      m_q = r_in;
    end else if (load) begin
      m_q = r_in;
    end else if (branch_en) begin
      m_q = model_br(m_q, offset);
    end else if (incr_pc) begin
      m_q = model_inc(m_q);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},     32'(q),           32'(m_q));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    check({tag, ".ovf"},   32'(overflow),    32'(m_ovf));
    check({tag, ".unf"},   32'(underflow),   32'(m_unf));
  endtask

  // One clock: drive at negedge, model advances at posedge, sample at negedge.
  task automatic cycle(input logic rn, input logic st, input logic inc, input logic ld,
                       input logic [W-1:0] rv, input logic br, input logic [W-1:0] off,
                       input logic cl, input logic rt);
    resetn = rn; stall = st; incr_pc = inc; load = ld; r_in = rv;
    branch_en = br; offset = off; call = cl; ret = rt;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle();             cycle(1, 0, 0, 0, '0, 0, '0, 0, 0); endtask
  task automatic do_inc();           cycle(1, 0, 1, 0, '0, 0, '0, 0, 0); endtask
  task automatic do_load(input logic [W-1:0] v); cycle(1, 0, 0, 1, v, 0, '0, 0, 0); endtask
  task automatic do_br(input logic [W-1:0] o);   cycle(1, 0, 0, 0, '0, 1, o, 0, 0); endtask
  task automatic do_call(input logic [W-1:0] v); cycle(1, 0, 0, 0, v, 0, '0, 1, 0); endtask
  task automatic do_ret();           cycle(1, 0, 0, 0, '0, 0, '0, 0, 1); endtask
  task automatic do_reset();         cycle(0, 0, 0, 0, '0, 0, '0, 0, 0); endtask

  initial begin
    m_q = RVEC; m_ovf = 1'b0; m_unf = 1'b0;
    resetn = 1'b0; stall = 1'b0; incr_pc = 1'b0; load = 1'b0; r_in = '0;
    branch_en = 1'b0; offset = '0; call = 1'b0; ret = 1'b0;
    @(negedge clock);

    // Reset then three increments
    do_reset();
    check_all("reset");
    check("reset.q_vec", 32'(q), 32'h0010);
    do_inc(); check("inc1", 32'(q), 32'h0011);
    do_inc(); check("inc2", 32'(q), 32'h0012);
    do_inc(); check("inc3", 32'(q), 32'h0013);
    check_all("inc");

    // Negative branch, then increment at all-ones
    do_load(16'h0100);
    do_br(16'hFFFE); check("br_neg", 32'(q), 32'h00FE);
    do_load(16'hFFFF);
    do_inc();
`ifdef PC_SAT_EN
    check("inc_top", 32'(q), 32'hFFFF);
`else
    check("inc_top", 32'(q), 32'h0000);
`endif
    // Load beats IncrPc, no +1
    cycle(1, 0, 1, 1, 16'h0ABC, 0, '0, 0, 0);
    check("load_over_inc", 32'(q), 32'h0ABC);

    // Simple call/return
    do_load(16'h0020);
    do_call(16'h0200); check("call_q", 32'(q), 32'h0200);
    check("call_nonempty", 32'(stack_empty), 32'd0);
    do_ret(); check("ret_q", 32'(q), 32'h0021);
    check_all("callret");

    // Five nested calls into a four-deep stack
    do_load(16'h0000);
    do_call(16'h1000); do_call(16'h2000); do_call(16'h3000); do_call(16'h4000);
    check("full4", 32'(stack_full), 32'd1);
    check("no_ovf4", 32'(overflow), 32'd0);
    do_call(16'h5000);
    check("ovf5", 32'(overflow), 32'd1);
    check_all("nest");
    do_ret(); check("ret1", 32'(q), 32'h4001);
    do_ret(); check("ret2", 32'(q), 32'h3001);
    do_ret(); check("ret3", 32'(q), 32'h2001);
    do_ret(); check("ret4", 32'(q), 32'h1001);
    do_ret(); check("ret5_hold", 32'(q), 32'h1001);
    check("unf", 32'(underflow), 32'd1);
    check_all("unwind");

    // Stall freezes everything; unstalled Call+Ret pops only
    do_reset();
    do_load(16'h0300);
    do_call(16'h0400);
    cycle(1, 1, 1, 0, 16'h0777, 0, '0, 1, 1);
    check("stall_q", 32'(q), 32'h0400);
    check_all("stall");
    cycle(1, 0, 0, 0, 16'h0777, 0, '0, 1, 1);
    check("callret_pop", 32'(q), 32'h0301);
    check("callret_empty", 32'(stack_empty), 32'd1);
    check_all("callret_both");

    // Reset during a call with two entries stacked
    do_call(16'h0500); do_call(16'h0600);
    cycle(0, 0, 0, 0, 16'h0900, 0, '0, 1, 0);
    check("rst_mid_q", 32'(q), 32'(RVEC));
    check("rst_mid_empty", 32'(stack_empty), 32'd1);
    check_all("rst_mid");

    // Positive branch wraps past all-ones
    do_load(16'hFFF0);
    do_br(16'h0020);
    check_all("br_pos_top");

    // Random strobes against the model
    for (int i = 0; i < 600; i++) begin
      logic rn, st, inc, ld, br, cl, rt;
      logic [W-1:0] rv, off;
      rn  = ($urandom_range(0, 63) != 0);
      st  = ($urandom_range(0, 7) == 0);
      inc = $urandom_range(0, 1) != 0;
      ld  = ($urandom_range(0, 5) == 0);
      br  = ($urandom_range(0, 4) == 0);
      cl  = ($urandom_range(0, 4) == 0);
      rt  = ($urandom_range(0, 4) == 0);
      rv  = W'($urandom);
      off = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 16) - 8);
      cycle(rn, st, inc, ld, rv, br, off, cl, rt);
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
